fm_audio_decim: RTL

//  Downstream of the FM discriminator. Takes the signed 16-bit demodulated stream at the sample rate.

---
 rtl/fm_audio_decim.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fm_audio_decim.sv
// FM audio decimator: accumulate-and-dump by DECIM, optional DC block, saturation to OUT_W, show-ahead FIFO.
// Build option: define FM_AUDIO_DCBLOCK_EN to enable the leaky DC-removal integrator.
`timescale 1ns/1ps
module fm_audio_decim #(
  parameter int DECIM      = 64,
  parameter int LOG2_DECIM = 6,
  parameter int OUT_W      = 12,
  parameter int DC_SHIFT   = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int MUTE_N     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [15:0]            in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int ACC_W = 16 + LOG2_DECIM;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int MW    = (MUTE_N > 0) ? $clog2(MUTE_N + 1) : 1;
  localparam int SH    = 16 - OUT_W;
  localparam logic signed [16:0] Z_MAX = 17'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [16:0] Z_MIN = 17'(-(1 << (OUT_W - 1)));

  if (DECIM != (1 << LOG2_DECIM)) begin : g_bad_decim
    $error("DECIM must equal 2**LOG2_DECIM");
  end
  if (DC_SHIFT < 1) begin : g_bad_dc_shift
    $error("DC_SHIFT must be at least 1");
  end

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [LOG2_DECIM-1:0]   cnt;
  logic signed [15:0]      avg;
  logic                    avg_vld;

  assign acc_sum = acc + ACC_W'(in_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      avg     <= '0;
      avg_vld <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      if (in_valid) begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          avg     <= 16'(acc_sum >>> LOG2_DECIM);
          avg_vld <= 1'b1;
          acc     <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  logic signed [15:0]      dc_int;
  logic signed [16:0]      y;
  logic signed [16:0]      z_full;
  logic signed [OUT_W-1:0] z_sat;
  logic [MW-1:0]           mute_cnt;
  logic                    muted;
  logic                    push;
  logic signed [OUT_W-1:0] push_data;

  always_comb begin
    y      = 17'(avg) - 17'(dc_int);
    z_full = y >>> SH;
    if (z_full > Z_MAX)      z_sat = Z_MAX[OUT_W-1:0];
    else if (z_full < Z_MIN) z_sat = Z_MIN[OUT_W-1:0];
    else                     z_sat = z_full[OUT_W-1:0];
  end

  assign muted     = mute_cnt < MW'(MUTE_N);
  assign push      = avg_vld;
  assign push_data = muted ? '0 : z_sat;

`ifdef FM_AUDIO_DCBLOCK_EN
  localparam int DC_W = 17 + DC_SHIFT;
  logic signed [DC_W-1:0] dc_acc;

  assign dc_int = 16'(dc_acc >>> DC_SHIFT);

  // Estimator keeps integrating during mute so it has settled when audio is released.
  always_ff @(posedge clk) begin
    if (rst)          dc_acc <= '0;
    else if (avg_vld) dc_acc <= dc_acc + DC_W'(y);
  end
`else
  assign dc_int = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst)                 mute_cnt <= '0;
    else if (push && muted)  mute_cnt <= mute_cnt + 1'b1;
  end

  logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic signed [OUT_W-1:0] last_pop;
  logic                    full;
  logic                    pop;
  logic                    wr_en;

  assign out_valid = fifo_level != '0;
  assign full      = fifo_level == (AW + 1)'(FIFO_DEPTH);
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : last_pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      last_pop   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_pop <= mem[rd_ptr];
      end
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      // A fresh drop outranks a clear in the same cycle.
      if (push && !wr_en) overflow <= 1'b1;
      else if (clr_ovf)   overflow <= 1'b0;
    end
  end

endmodule
